big_merge: RTL
==============

# big_merge

Five-input, single-output registered merge with round-robin arbitration. It is the counterpart of the four-way-plus-core split. It collects 11-bit words from four port inputs and one core input and emits them on a single output channel. Each output word carries the routing tags the split consumes: `out_port` (2-bit control) and `out_from_core` (core select). It sits at the egress of a router tile, feeding the tile's downstream link.

## Interface
Parameters:
- `WIDTH`, 11, data word width.
- `NPORT`, 4, number of port inputs (fixed at 4; tag width is 2).

Ports:
- `clk` in 1: single clock, rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_data` in NPORT×WIDTH: port input words; index i is port i.
- `in_valid` in NPORT: port input valid.
- `in_ready` out NPORT: port input ready.
- `core_data` in WIDTH: core input word.
- `core_valid` in 1: core input valid.
- `core_ready` out 1: core input ready.
- `out_data` out WIDTH: merged word.
- `out_port` out 2: source port index (0–3); 0 when the word came from core.
- `out_from_core` out 1: 1 means the word came from the core input.
- `out_valid` out 1: output valid.
- `out_ready` in 1: downstream ready.

## Operation
- There are five requesters: index 0–3 are ports, index 4 is core. `req[k]` is the corresponding valid.
- The output register is a one-entry buffer holding `out_data`, `out_port`, `out_from_core` and `out_valid`.
- `load = !out_valid | out_ready`: the register is empty or is draining this cycle.
- On `load` with any `req`, grant one requester:
  - The winner is the first set `req` found scanning from `rr_ptr` upward, mod 5.
  - Only the granted input sees ready = 1. All other readies are 0.
  - Ready is combinational from `req`, `rr_ptr`, `out_valid` and `out_ready`. It never depends on the same input's data.
- Transfer on an input happens when its valid and ready are both 1.
- On transfer, the register captures:
  - the word;
  - `out_port` = k when k < 4, otherwise 0;
  - `out_from_core` = (k == 4).
  - `out_valid` becomes 1.
- On transfer, `rr_ptr` becomes (k+1) mod 5.
- On `load` with no `req`, `out_valid` becomes 0 and `rr_ptr` is unchanged.
- When `out_valid=1` and `out_ready=0` (stall):
  - the register holds all fields stable;
  - every input ready is 0.
- Fairness: any requester held valid is granted within 5 grants.
- Inputs follow valid/ready rules. Once valid is asserted, data must stay stable until transfer. The block does not check this.

## Timing
- Reset values:
  - `out_valid`=0, `out_data`=0, `out_port`=0, `out_from_core`=0, `rr_ptr`=0.
  - All readies are 0 while `rst_n`=0.
- Reset asserted mid-transfer discards the held word. There is no replay.
- Latency: a transfer in cycle N appears with `out_valid`=1 in cycle N+1.
- Throughput: one word per cycle while `out_ready`=1.
- Simultaneous drain and refill in the same cycle is allowed. `out_valid` stays 1 with the new word; there is no bubble.
- All five valid every cycle with `out_ready`=1: grant order is 0,1,2,3,4,0,…
- Pointer wrap: after granting core (4), `rr_ptr` returns to 0.

## Configuration
- Macro `BIG_MERGE_CORE_PRIORITY_EN` selects the core arbitration policy:
  - Defined: core has strict priority. When `core_valid`=1 on `load`, core is granted regardless of `rr_ptr`, and `rr_ptr` is not updated on a core grant. Ports round-robin among 0–3 only, with the pointer wrapping mod 4.
  - Undefined: pure 5-way round robin as described above.

## Structure
- Package `big_merge_pkg` holds:
  - `WIDTH_DEFAULT`=11;
  - `NREQ`=5;
  - `CORE_IDX`=4;
  - typedef `req_idx_t` (3-bit);
  - typedef `merge_word_t`, a struct of data, port and from_core.
- Sub-module `rr_arbiter`:
  - parameter N;
  - inputs `req`, `ptr` and `en`;
  - outputs one-hot `gnt` and encoded `gnt_idx`;
  - purely combinational.
- The pointer register and the output register live in `big_merge`.

## Test plan
- Reset then idle: hold `rst_n`=0 with all valids at 1 → all readies 0 and `out_valid`=0. Release → first grant is port 0.
- Single source: port 2 sends 0x5A3 → next cycle `out_data`=0x5A3, `out_port`=2, `out_from_core`=0.
- Core source: core sends 0x7FF → `out_data`=0x7FF, `out_from_core`=1, `out_port`=0.
- Full contention: all five valid with `out_ready`=1 for 10 cycles → source sequence 0,1,2,3,4,0,1,2,3,4, with no bubbles.
- Backpressure: `out_ready`=0 for 3 cycles while holding port 1's word → output stable and all readies 0. Raise `out_ready` → same-cycle refill from the next requester.
- `BIG_MERGE_CORE_PRIORITY_EN` defined, core plus ports 0 and 3 all valid → core is granted every cycle. Drop `core_valid` → ports 0,3,0,3 alternate.

Source files
------------

// File: rtl/big_merge_pkg.sv
// big_merge_pkg: shared constants and types for the big_merge egress merge.
//   WIDTH_DEFAULT : default data word width
//   NPORT_DEFAULT : number of port requesters (fixed at 4, 2-bit tag)
//   NREQ          : total requesters (4 ports + core)
//   CORE_IDX      : requester index of the core input
//   req_idx_t     : encoded requester index
//   merge_word_t  : contents of the output register (data + routing tags)
package big_merge_pkg;

    localparam int WIDTH_DEFAULT = 11;
    localparam int NPORT_DEFAULT = 4;
    localparam int NREQ          = 5;

    typedef logic [2:0] req_idx_t;

    localparam req_idx_t CORE_IDX = 3'd4;

    typedef struct packed {
        logic [WIDTH_DEFAULT-1:0] data;
        logic [1:0]               port;
        logic                     from_core;
    } merge_word_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter.
// The winner is the first set request found scanning upward from ptr, mod N.
//   req     in  N : request vector
//   ptr     in  3 : index with highest priority this cycle (must be < N)
//   en      in  1 : grant enable; no grant when low
//   gnt     out N : one-hot grant
//   gnt_idx out 3 : encoded grant index (0 when no grant)
module rr_arbiter
    import big_merge_pkg::*;
#(
    parameter int N = NREQ
) (
    input  logic [N-1:0] req,
    input  req_idx_t     ptr,
    input  logic         en,
    output logic [N-1:0] gnt,
    output req_idx_t     gnt_idx
);

    localparam int unsigned NU = N;

    logic found;

    // Outer loop walks the priority offset from ptr; inner loop matches the
    // rotated position against a constant index so every select stays static.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        for (int unsigned i = 0; i < NU; i++) begin
            for (int unsigned k = 0; k < NU; k++) begin
                if (en && !found && req[k] && (k == ((32'(ptr) + i) % NU))) begin
                    gnt[k]  = 1'b1;
                    gnt_idx = req_idx_t'(k);
                    found   = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/big_merge.sv
// big_merge: five-input (4 ports + core) registered merge with round-robin
// arbitration into a single one-entry output register.
//   clk, rst_n          : clock (rising edge), async active-low reset
//   in_data/valid/ready : NPORT port inputs, word i at in_data[i*WIDTH +: WIDTH]
//   core_data/valid/ready : core input
//   out_data/out_port/out_from_core/out_valid/out_ready : merged output
// Build option BIG_MERGE_CORE_PRIORITY_EN: core gets strict priority and the
// ports round-robin among themselves (pointer mod 4, untouched on core grants).
// Otherwise all five requesters share one 5-way round robin.
// The output register's data field is sized by WIDTH_DEFAULT, so WIDTH must
// stay at its default.
module big_merge
    import big_merge_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int NPORT = NPORT_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NPORT*WIDTH-1:0] in_data,
    input  logic [NPORT-1:0]       in_valid,
    output logic [NPORT-1:0]       in_ready,
    input  logic [WIDTH-1:0]       core_data,
    input  logic                   core_valid,
    output logic                   core_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [1:0]             out_port,
    output logic                   out_from_core,
    output logic                   out_valid,
    input  logic                   out_ready
);

    merge_word_t      word_q, word_d;
    logic             out_valid_q, out_valid_d;
    req_idx_t         rr_ptr_q, rr_ptr_d;
    req_idx_t         ptr_next;

    logic             load;
    logic             en;
    logic [NREQ-1:0]  gnt;
    req_idx_t         gnt_idx;
    logic [WIDTH-1:0] port_words [NPORT];

    for (genvar g = 0; g < NPORT; g++) begin : g_unpack
        assign port_words[g] = in_data[g*WIDTH +: WIDTH];
    end

    assign load = ~out_valid_q | out_ready;
    // Gating with rst_n keeps every ready low while reset is held, even though
    // the emptied register would otherwise make load true.
    assign en   = load & rst_n;

`ifdef BIG_MERGE_CORE_PRIORITY_EN
    logic [NPORT-1:0] port_gnt;
    req_idx_t         port_idx;
    logic             core_gnt;

    assign core_gnt = en & core_valid;

    rr_arbiter #(.N(NPORT)) u_arb (
        .req     (in_valid),
        .ptr     (rr_ptr_q),
        .en      (en & ~core_valid),
        .gnt     (port_gnt),
        .gnt_idx (port_idx)
    );

    assign gnt      = {core_gnt, port_gnt};
    assign gnt_idx  = core_gnt ? CORE_IDX : port_idx;
    assign ptr_next = core_gnt ? rr_ptr_q
                    : ((port_idx == 3'(NPORT-1)) ? '0 : port_idx + 3'd1);
`else
    rr_arbiter #(.N(NREQ)) u_arb (
        .req     ({core_valid, in_valid}),
        .ptr     (rr_ptr_q),
        .en      (en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign ptr_next = (gnt_idx == CORE_IDX) ? '0 : gnt_idx + 3'd1;
`endif

    // Every grant is also a transfer: a requester is only granted while its
    // valid is high, and ready is exactly the grant.
    always_comb begin
        word_d      = word_q;
        out_valid_d = out_valid_q;
        rr_ptr_d    = rr_ptr_q;
        if (load) begin
            if (|gnt) begin
                out_valid_d = 1'b1;
                rr_ptr_d    = ptr_next;
                if (gnt_idx == CORE_IDX) begin
                    word_d.data      = WIDTH_DEFAULT'(core_data);
                    word_d.port      = '0;
                    word_d.from_core = 1'b1;
                end else begin
                    word_d.data      = WIDTH_DEFAULT'(port_words[gnt_idx[1:0]]);
                    word_d.port      = gnt_idx[1:0];
                    word_d.from_core = 1'b0;
                end
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q      <= '0;
            out_valid_q <= 1'b0;
            rr_ptr_q    <= '0;
        end else begin
            word_q      <= word_d;
            out_valid_q <= out_valid_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign in_ready      = gnt[NPORT-1:0];
    assign core_ready    = gnt[NREQ-1];
    assign out_data      = WIDTH'(word_q.data);
    assign out_port      = word_q.port;
    assign out_from_core = word_q.from_core;
    assign out_valid     = out_valid_q;

endmodule
